dsc_mul_sequencer: RTL and testbench
====================================

# dsc_mul_sequencer

Sequencing controller for the deterministic-stochastic multi-input multiplier datapath. It accepts one operand set per transaction over a valid/ready handshake and holds the operands stable for the datapath. It then clears the datapath, enables it until the datapath signals `done` (or a watchdog expires), captures the accumulated binary result, and presents it downstream over a second valid/ready handshake. It sits between the sweep harness or host FIFO and one multiplier instance.

## Interface
- `DATA_WIDTH`, 5, width of each operand.
- `NUM_INPUTS`, 2, number of operands, range 2..5.
- `WXIP1`, `DATA_WIDTH*NUM_INPUTS`, width of the result.
- `DRAIN_CYCLES`, 1, cycles to wait after `done` before capturing the result (covers accumulator register lag), range 1..3.
- `MAX_CYCLES`, `2**(DATA_WIDTH*NUM_INPUTS)`, watchdog limit on RUN cycles.
- `CNT_W`, `DATA_WIDTH*NUM_INPUTS+1`, width of the run-cycle counter.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  operand set valid.
- `in_ready`  out  1  sequencer accepts an operand set.
- `in_data`  in  `DATA_WIDTH*NUM_INPUTS`  operand i at bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `mul_operands`  out  `DATA_WIDTH*NUM_INPUTS`  latched operands driven to the datapath.
- `mul_rst`  out  1  datapath reset, active-high.
- `mul_en`  out  1  datapath enable.
- `mul_done`  in  1  datapath done.
- `mul_result`  in  `WXIP1`  datapath accumulator value.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_data`  out  `WXIP1`  captured result.
- `out_cycles`  out  `CNT_W`  number of RUN cycles consumed.
- `out_timeout`  out  1  set when the watchdog ended the run.
- `busy`  out  1  state is not IDLE.

## Operation
- FSM states: IDLE, CLEAR, RUN, DRAIN, HOLD. All outputs are registered.
- IDLE:
  - `in_ready=1`, `mul_rst=1`, `mul_en=0`.
  - On `in_valid`: latch `in_data` into `mul_operands`, go to CLEAR.
- CLEAR:
  - Exactly 1 cycle with `mul_rst=1` and operands stable.
  - `mul_done` is ignored. Run counter is cleared to 0.
  - Go to RUN.
- RUN:
  - `mul_rst=0`, `mul_en=1`, counter increments every cycle.
  - `mul_done` sampled 1: go to DRAIN with timeout flag 0.
  - Else if counter reaches `MAX_CYCLES`: go to DRAIN with timeout flag 1.
  - If both happen on the same edge, done wins and the timeout flag is 0.
- DRAIN:
  - `mul_en=0`, `mul_rst=0`. Wait `DRAIN_CYCLES` cycles.
  - On the last cycle: capture `mul_result` into `out_data`, the counter into `out_cycles`, and the flag into `out_timeout`. Go to HOLD.
- HOLD:
  - `out_valid=1`. `out_data`, `out_cycles` and `out_timeout` stay stable until the handshake completes.
  - On `out_ready`: if `in_valid` is also high, accept the new set and go to CLEAR; otherwise go to IDLE.
  - `in_ready = (IDLE) | (HOLD & out_ready)`.
- `mul_operands` change only on an accepted input handshake.
- Counter saturates at `MAX_CYCLES` and never wraps.

## Timing
- Reset values:
  - State IDLE.
  - `in_ready=1`, `mul_rst=1`.
  - `mul_en=0`, `out_valid=0`, `busy=0`, `out_timeout=0`.
  - `mul_operands=0`, `out_data=0`, `out_cycles=0`.
- Handshake accepted at edge k:
  - CLEAR during cycle k+1.
  - RUN starts at cycle k+2.
- `mul_done` first sampled high at RUN cycle N (1-based):
  - DRAIN starts the next cycle.
  - `out_valid` rises at cycle k+2+N+DRAIN_CYCLES, with `out_cycles=N`.
- `mul_done` high on the first RUN cycle (zero operand) is legal and gives N=1.
- `rst` asserted in any state: all outputs go to their reset values immediately and any in-flight result is discarded. First acceptance is possible one cycle after reset deasserts.
- `in_valid` must hold until accepted; the sequencer never drops a set it has offered `in_ready` for.

## Structure
- Package `dsc_seq_pkg`:
  - State enum typedef `seq_state_t`.
  - Function `clog2`.
  - Default `DRAIN_CYCLES` constant.
- Sub-module `dsc_run_ctr`: clear/enable saturating counter with terminal-count compare output. Used for both RUN counting and DRAIN countdown.
- The FSM and handshake registers stay in the top module.

## Test plan
- Bench uses a behavioural multiplier stub that asserts done on a programmable RUN cycle and returns a programmable result.
- Operands {16,16}, stub done at RUN cycle 7, result 0x0A5:
  - `out_data=0x0A5`, `out_cycles=7`, `out_timeout=0`.
  - `out_valid` rises 10 cycles after accept.
- Stub never asserts done, `MAX_CYCLES=1024`:
  - `out_timeout=1`, `out_cycles=1024`.
  - `mul_en` high for exactly 1024 cycles.
- `out_ready` held low 20 cycles in HOLD:
  - `out_data` stable, `in_ready=0` until release.
  - Release with `in_valid` high gives CLEAR on the next cycle (back-to-back, no IDLE).
- Done on the first RUN cycle (zero operand):
  - `out_cycles=1`.
  - Done asserted during CLEAR is ignored.
- `rst` low mid-RUN at cycle 3:
  - `mul_en=0`, `mul_rst=1`, `out_valid=0` immediately.
  - Next transaction completes normally.
- Done and watchdog expiry on the same edge: `out_timeout=0`.

Source files
------------

// File: rtl/dsc_seq_pkg.sv
// Shared types and constants for the multiplier sequencer.
package dsc_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_HOLD
    } seq_state_t;

    localparam int DRAIN_CYCLES_DEFAULT = 1;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dsc_run_ctr.sv
// Clear/enable saturating up-counter; tc flags the cycle whose increment reaches limit.
module dsc_run_ctr #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         tc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != limit)) begin
            count <= count + W'(1);
        end
    end

    // Widened by one bit so limit = all-ones cannot wrap the compare.
    assign tc = (({1'b0, count} + (W + 1)'(1)) == {1'b0, limit});

endmodule

// File: rtl/dsc_mul_sequencer.sv
// Operand-in / result-out sequencer wrapping one stochastic multiplier datapath.
//   state | meaning
//   IDLE  | waiting for an operand set, datapath held in reset
//   CLEAR | one cycle of datapath reset with new operands stable
//   RUN   | datapath enabled until done or watchdog expiry
//   DRAIN | datapath idle while the accumulator settles
//   HOLD  | result presented downstream until accepted
module dsc_mul_sequencer
    import dsc_seq_pkg::*;
#(
    parameter int DATA_WIDTH   = 5,
    parameter int NUM_INPUTS   = 2,
    parameter int WXIP1        = DATA_WIDTH * NUM_INPUTS,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT,
    parameter int MAX_CYCLES   = 2 ** (DATA_WIDTH * NUM_INPUTS),
    parameter int CNT_W        = DATA_WIDTH * NUM_INPUTS + 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_WIDTH*NUM_INPUTS-1:0] in_data,
    output logic [DATA_WIDTH*NUM_INPUTS-1:0] mul_operands,
    output logic                             mul_rst,
    output logic                             mul_en,
    input  logic                             mul_done,
    input  logic [WXIP1-1:0]                 mul_result,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [WXIP1-1:0]                 out_data,
    output logic [CNT_W-1:0]                 out_cycles,
    output logic                             out_timeout,
    output logic                             busy
);

    seq_state_t       state;
    logic [CNT_W-1:0] ctr_count;
    logic [CNT_W-1:0] ctr_limit;
    logic [CNT_W-1:0] cycles_q;
    logic             ctr_clr;
    logic             ctr_en;
    logic             ctr_tc;
    logic             timeout_q;

    // One counter serves both phases: run length is parked in cycles_q so
    // the counter can be recycled for the drain countdown.
    assign ctr_limit = (state == S_DRAIN) ? CNT_W'(DRAIN_CYCLES) : CNT_W'(MAX_CYCLES);
    assign ctr_clr   = (state == S_CLEAR) || ((state == S_RUN) && (mul_done || ctr_tc));
    assign ctr_en    = (state == S_RUN) || (state == S_DRAIN);
    assign in_ready  = (state == S_IDLE) || ((state == S_HOLD) && out_ready);

    dsc_run_ctr #(
        .W(CNT_W)
    ) u_run_ctr (
        .clk  (clk),
        .rst_n(rst),
        .clr  (ctr_clr),
        .en   (ctr_en),
        .limit(ctr_limit),
        .count(ctr_count),
        .tc   (ctr_tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            mul_rst      <= 1'b1;
            mul_en       <= 1'b0;
            out_valid    <= 1'b0;
            busy         <= 1'b0;
            out_timeout  <= 1'b0;
            mul_operands <= '0;
            out_data     <= '0;
            out_cycles   <= '0;
            timeout_q    <= 1'b0;
            cycles_q     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        mul_operands <= in_data;
                        busy         <= 1'b1;
                        state        <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    mul_rst <= 1'b0;
                    mul_en  <= 1'b1;
                    state   <= S_RUN;
                end
                S_RUN: begin
                    // done has priority over a watchdog expiry on the same edge
                    if (mul_done || ctr_tc) begin
                        timeout_q <= !mul_done;
                        cycles_q  <= ctr_count + CNT_W'(1);
                        mul_en    <= 1'b0;
                        state     <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (ctr_tc) begin
                        out_data    <= mul_result;
                        out_cycles  <= cycles_q;
                        out_timeout <= timeout_q;
                        out_valid   <= 1'b1;
                        state       <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        mul_rst   <= 1'b1;
                        if (in_valid) begin
                            mul_operands <= in_data;
                            state        <= S_CLEAR;
                        end else begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dsc_mul_sequencer.sv
// Scoreboard bench: stimulus queues spec-derived expectations, a monitor checks each result.
module tb_dsc_mul_sequencer;

    localparam int OW   = 10;
    localparam int CW   = 11;
    localparam int MAXC = 1024;
    localparam int DR   = 1;

    typedef struct {
        logic [OW-1:0] data;
        int            cycles;
        bit            timeout;
        int            acc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [OW-1:0] in_data;
    logic [OW-1:0] mul_operands;
    logic          mul_rst;
    logic          mul_en;
    logic          mul_done;
    logic [OW-1:0] mul_result;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;
    logic [CW-1:0] out_cycles;
    logic          out_timeout;
    logic          busy;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t sbq[$];

    // multiplier stub configuration: pending (offered) and current (accepted)
    int            pend_done_at = 0;
    logic [OW-1:0] pend_res = '0;
    bit            pend_cd = 1'b0;
    int            cur_done_at = 0;
    logic [OW-1:0] cur_res = '0;
    bit            cur_cd = 1'b0;
    int            run_n = 0;
    bit            done_seen = 1'b0;

    always #5 clk = ~clk;

    dsc_mul_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .mul_operands(mul_operands),
        .mul_rst     (mul_rst),
        .mul_en      (mul_en),
        .mul_done    (mul_done),
        .mul_result  (mul_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_cycles  (out_cycles),
        .out_timeout (out_timeout),
        .busy        (busy)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Stub: done on the programmed 1-based enabled cycle; optionally a spurious
    // done while held in reset during a transaction. Result is only correct
    // once done has been seen, so early or timed-out captures read ~res.
    always @(posedge clk) begin
        if (in_valid && in_ready) begin
            cur_done_at <= pend_done_at;
            cur_res     <= pend_res;
            cur_cd      <= pend_cd;
        end
        if (mul_rst) begin
            run_n     <= 0;
            done_seen <= 1'b0;
        end else if (mul_en) begin
            run_n <= run_n + 1;
            if (mul_done) done_seen <= 1'b1;
        end
    end

    assign mul_done   = (mul_en && cur_done_at != 0 && (run_n + 1) == cur_done_at) ||
                        (mul_rst && busy && cur_cd);
    assign mul_result = done_seen ? cur_res : ~cur_res;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, want, $time);
        end
    endtask

    function automatic exp_t model(input int dat, input logic [OW-1:0] res, input int acc);
        exp_t e;
        e.acc = acc;
        if (dat >= 1 && dat <= MAXC) begin
            e.cycles  = dat;
            e.timeout = 1'b0;
            e.data    = res;
        end else begin
            e.cycles  = MAXC;
            e.timeout = 1'b1;
            e.data    = ~res;
        end
        return e;
    endfunction

    // Returns at the negedge of the CLEAR cycle following acceptance.
    task automatic send(input logic [OW-1:0] d, input int dat, input logic [OW-1:0] res,
                        input bit cd, input bit rel);
        bit ok;
        @(posedge clk);
        #1;
        in_valid     = 1'b1;
        in_data      = d;
        pend_done_at = dat;
        pend_res     = res;
        pend_cd      = cd;
        if (rel) out_ready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 4000 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                sbq.push_back(model(dat, res, cyc + 1));
            end
        end
        if (!ok) begin
            chk("send_accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = OW'($urandom);
        @(negedge clk);
        chk("operands", mul_operands, d);
    endtask

    task automatic wait_valid();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (out_valid) ok = 1'b1;
        end
        if (!ok) chk("wait_valid_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 5000 && !ok; i++) begin
            @(negedge clk);
            if (!busy && sbq.size() == 0) ok = 1'b1;
        end
        if (!ok) chk("wait_idle_timeout", 0, 1);
    endtask

    // Monitor. Cycle after accept edge k is CLEAR (k+1); with done on RUN cycle N
    // the result is visible right after edge k+1+N+DR.
    initial begin
        bit            prev_ov;
        int            en_cnt;
        logic [OW-1:0] held_data;
        logic [CW-1:0] held_cyc;
        logic          held_to;
        exp_t          e;
        prev_ov = 1'b0;
        en_cnt  = 0;
        held_data = '0;
        held_cyc  = '0;
        held_to   = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_ov = 1'b0;
                en_cnt  = 0;
            end else begin
                if (mul_rst) en_cnt = 0;
                else if (mul_en) en_cnt++;
                if (out_valid && !prev_ov) begin
                    if (sbq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_out: got out_valid=1 want no pending result (t=%0t)", $time);
                    end else begin
                        chk("latency", cyc - sbq[0].acc, sbq[0].cycles + DR + 1);
                        held_data = out_data;
                        held_cyc  = out_cycles;
                        held_to   = out_timeout;
                    end
                end
                if (out_valid && !out_ready) chk("in_ready_stall", in_ready, 0);
                if (out_valid && out_ready && sbq.size() > 0) begin
                    e = sbq.pop_front();
                    chk("out_data", out_data, e.data);
                    chk("out_cycles", out_cycles, e.cycles);
                    chk("out_timeout", out_timeout, e.timeout);
                    chk("hold_stable", {out_timeout, out_cycles, out_data}, {held_to, held_cyc, held_data});
                    chk("mul_en_cycles", en_cnt, e.cycles);
                end
                prev_ov = out_valid;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int dat;
        bit stall;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        #23;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_mul_rst", mul_rst, 1);
        chk("rst_mul_en", mul_en, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_timeout", out_timeout, 0);
        chk("rst_operands", mul_operands, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_cycles", out_cycles, 0);
        @(posedge clk);
        #1 rst = 1'b1;

        // operands {16,16}, done on RUN cycle 7
        send({5'd16, 5'd16}, 7, 10'h0A5, 1'b0, 1'b0);
        wait_idle();

        // watchdog expiry, done only at limit, done one past limit
        send(10'h3ff, 0, 10'h155, 1'b0, 1'b0);
        wait_idle();
        send(10'h2b7, MAXC, 10'h1c3, 1'b0, 1'b0);
        wait_idle();
        send(10'h0f0, MAXC + 1, 10'h27e, 1'b0, 1'b0);
        wait_idle();

        // zero operand: done on first RUN cycle; then spurious done during CLEAR
        send(10'h000, 1, 10'h3a0, 1'b0, 1'b0);
        wait_idle();
        send(10'h005, 4, 10'h07e, 1'b1, 1'b0);
        wait_idle();

        // 20+ cycle stall in HOLD, released together with the next set
        send(10'h021, 3, 10'h2aa, 1'b0, 1'b0);
        @(posedge clk);
        #1 out_ready = 1'b0;
        wait_valid();
        repeat (20) @(posedge clk);
        send(10'h0f3, 5, 10'h0c3, 1'b0, 1'b1);
        chk("b2b_busy", busy, 1);
        chk("b2b_in_ready", in_ready, 0);
        chk("b2b_mul_rst", mul_rst, 1);
        chk("b2b_out_valid", out_valid, 0);
        wait_idle();

        // reset during RUN cycle 3
        send(10'h3c5, 50, 10'h111, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_mul_en", mul_en, 1);
        rst = 1'b0;
        #1;
        chk("arst_mul_en", mul_en, 0);
        chk("arst_mul_rst", mul_rst, 1);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_operands", mul_operands, 0);
        sbq.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        send(10'h19c, 9, 10'h2d4, 1'b0, 1'b0);
        wait_idle();

        // randomized traffic with occasional downstream stalls
        for (int t = 0; t < 30; t++) begin
            dat   = $urandom_range(1, 40);
            stall = ($urandom_range(0, 2) == 0);
            send(OW'($urandom), dat, OW'($urandom), 1'($urandom_range(0, 1)), 1'b0);
            if (stall) begin
                @(posedge clk);
                #1 out_ready = 1'b0;
                wait_valid();
                repeat ($urandom_range(1, 6)) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        end
        wait_idle();
        chk("scoreboard_empty", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
